ptw_sv32: RTL and testbench



---
 rtl/ptw_sv32_pkg.sv | 45 ++++
 rtl/ptw_sv32_pte_check.sv | 42 ++++
 rtl/ptw_sv32.sv | 226 ++++++++++++++++++++++
 tb/tb_ptw_sv32.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_sv32_pkg.sv
// Shared types and constants for the Sv32 page-table walker: FSM state
// encoding, completion cause codes, Sv32 PTE field positions and a helper
// for building a PTE byte address from a table PPN and a VPN slice.
package ptw_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_L1_REQ,
    S_L1_WAIT,
    S_L0_REQ,
    S_L0_WAIT,
    S_FILL,
    S_FAULT,
    S_DRAIN,
    S_ABORT
  } ptw_state_e;

  localparam logic [1:0] PTW_OK    = 2'd0;
  localparam logic [1:0] PTW_PF    = 2'd1;
  localparam logic [1:0] PTW_AF    = 2'd2;
  localparam logic [1:0] PTW_FLUSH = 2'd3;

  localparam int PTE_V        = 0;
  localparam int PTE_R        = 1;
  localparam int PTE_W        = 2;
  localparam int PTE_X        = 3;
  localparam int PTE_U        = 4;
  localparam int PTE_G        = 5;
  localparam int PTE_A        = 6;
  localparam int PTE_D        = 7;
  localparam int PTE_PPN_LSB  = 10;
  localparam int PTE_PPN_MSB  = 31;
  localparam int PTE_PPN0_LSB = 10;
  localparam int PTE_PPN0_MSB = 19;

  function automatic logic [21:0] pte_ppn(input logic [31:0] pte);
    return pte[PTE_PPN_MSB:PTE_PPN_LSB];
  endfunction

  // Byte address of entry idx within the 4 KiB table at ppn.
  function automatic logic [33:0] pte_addr(input logic [21:0] ppn, input logic [9:0] idx);
    return {ppn, 12'h000} + {22'h0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/ptw_sv32_pte_check.sv
// Combinational Sv32 PTE classifier. level=1 means the entry came from the
// root table (a leaf there is a 4 MiB megapage), level=0 the second table.
module ptw_pte_check
  import ptw_pkg::*;
(
  input  logic [31:0] pte,
  input  logic        level,
  input  logic        store,
  output logic        is_leaf,
  output logic        page_fault
);

  logic v, r, w, x, a, d;
  logic unused_bits;

  assign v = pte[PTE_V];
  assign r = pte[PTE_R];
  assign w = pte[PTE_W];
  assign x = pte[PTE_X];
  assign a = pte[PTE_A];
  assign d = pte[PTE_D];

  // U, G, RSW and the upper PPN bits do not affect classification.
  assign unused_bits = ^{pte[PTE_PPN_MSB:PTE_PPN0_MSB+1], pte[9:8], pte[PTE_U], pte[PTE_G]};

  // Classify: invalid / reserved encodings, pointer at the last level,
  // missing A/D (no hardware update), and misaligned megapages all fault.
  always_comb begin
    is_leaf    = r | x;
    page_fault = 1'b0;
    if (!v || (!r && w)) begin
      page_fault = 1'b1;
    end else if (!is_leaf) begin
      page_fault = !level;
    end else if (!a || (store && !d)) begin
      page_fault = 1'b1;
    end else if (level && (pte[PTE_PPN0_MSB:PTE_PPN0_LSB] != 10'd0)) begin
      page_fault = 1'b1;
    end
  end

endmodule

// File: rtl/ptw_sv32.sv
// Sv32 hardware page-table walker. Services one TLB miss at a time, issues
// at most one outstanding PTE read, and either fills the TLB with the leaf
// PTE or reports a fault. A TLB flush aborts the walk, draining any read
// already granted so the memory port stays in step.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | ready for a miss; late memory responses are ignored here
// S_L1_REQ  | requesting root-table PTE, waiting for m_gnt
// S_L1_WAIT | root-table read granted, waiting for m_rvalid
// S_L0_REQ  | requesting second-level PTE, waiting for m_gnt
// S_L0_WAIT | second-level read granted, waiting for m_rvalid
// S_FILL    | write leaf into TLB, walk_done with cause ok (flush: cause 3)
// S_FAULT   | walk_done with latched fault cause (flush: cause 3)
// S_DRAIN   | flushed with a read in flight; wait for and discard its data
// S_ABORT   | walk_done with cause flushed
module ptw_sv32
  import ptw_pkg::*;
#(
  parameter int PTE_W = 64,
  parameter int PA_W  = 34
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             walk_req,
  input  logic [19:0]      walk_vpn,
  input  logic             walk_store,
  output logic             walk_ready,
  output logic             walk_done,
  output logic [1:0]       walk_cause,
  input  logic             satp_mode,
  input  logic [21:0]      satp_ppn,
  output logic             m_req,
  output logic [PA_W-1:0]  m_addr,
  input  logic             m_gnt,
  input  logic             m_rvalid,
  input  logic [31:0]      m_rdata,
  input  logic             m_rerr,
  output logic             tlb_cs,
  output logic             tlb_we,
  output logic [19:0]      tlb_vpn,
  output logic             tlb_spage,
  output logic [PTE_W-1:0] tlb_pte,
  input  logic             tlb_flush_req
);

  ptw_state_e  state_q, state_d;

  logic [19:0] vpn_q;
  logic        store_q;
  logic [21:0] ppn_q;
  logic [31:0] pte_q;
  logic        spage_q;
  logic [1:0]  cause_q;

  logic        accept;
  logic        load_ptr;
  logic        load_leaf;
  logic        set_cause;
  logic [1:0]  cause_d;
  logic        level_l1;
  logic        is_leaf;
  logic        page_fault;
  logic [33:0] addr_full;

  assign level_l1 = (state_q == S_L1_WAIT);

  ptw_pte_check u_pte_check (
    .pte        (m_rdata),
    .level      (level_l1),
    .store      (store_q),
    .is_leaf    (is_leaf),
    .page_fault (page_fault)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush overrides every transition except in IDLE
  // and DRAIN.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    load_ptr  = 1'b0;
    load_leaf = 1'b0;
    set_cause = 1'b0;
    cause_d   = PTW_PF;
    case (state_q)
      S_IDLE: begin
        if (walk_req) begin
          accept = 1'b1;
          if (satp_mode) begin
            state_d = S_L1_REQ;
          end else begin
            state_d   = S_FAULT;
            set_cause = 1'b1;
            cause_d   = PTW_PF;
          end
        end
      end
      S_L1_REQ, S_L0_REQ: begin
        if (tlb_flush_req) begin
          state_d = m_gnt ? S_DRAIN : S_ABORT;
        end else if (m_gnt) begin
          state_d = (state_q == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
        end
      end
      S_L1_WAIT, S_L0_WAIT: begin
        if (tlb_flush_req) begin
          state_d = m_rvalid ? S_ABORT : S_DRAIN;
        end else if (m_rvalid) begin
          if (m_rerr) begin
            state_d   = S_FAULT;
            set_cause = 1'b1;
            cause_d   = PTW_AF;
          end else if (page_fault) begin
            state_d   = S_FAULT;
            set_cause = 1'b1;
            cause_d   = PTW_PF;
          end else if (!is_leaf) begin
            state_d  = S_L0_REQ;
            load_ptr = 1'b1;
          end else begin
            state_d   = S_FILL;
            load_leaf = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (m_rvalid) begin
          state_d = S_ABORT;
        end
      end
      S_FILL, S_FAULT, S_ABORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Walk context: request fields on accept, next table PPN on a pointer,
  // leaf PTE and page size on a successful leaf, cause on a fault.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vpn_q   <= '0;
      store_q <= 1'b0;
      ppn_q   <= '0;
      pte_q   <= '0;
      spage_q <= 1'b0;
      cause_q <= PTW_OK;
    end else begin
      if (accept) begin
        vpn_q   <= walk_vpn;
        store_q <= walk_store;
        ppn_q   <= satp_ppn;
      end
      if (load_ptr) begin
        ppn_q <= pte_ppn(m_rdata);
      end
      if (load_leaf) begin
        pte_q   <= m_rdata;
        spage_q <= level_l1;
      end
      if (set_cause) begin
        cause_q <= cause_d;
      end
    end
  end

  assign addr_full = pte_addr(ppn_q, (state_q == S_L1_REQ) ? vpn_q[19:10] : vpn_q[9:0]);

  // Outputs decoded from state; only the completion cause and the TLB
  // write strobe look at the flush input directly.
  always_comb begin
    walk_ready = 1'b0;
    walk_done  = 1'b0;
    walk_cause = PTW_OK;
    m_req      = 1'b0;
    m_addr     = '0;
    tlb_cs     = 1'b0;
    tlb_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        walk_ready = 1'b1;
      end
      S_L1_REQ, S_L0_REQ: begin
        m_req  = 1'b1;
        m_addr = PA_W'(addr_full);
      end
      S_FILL: begin
        walk_done = 1'b1;
        if (tlb_flush_req) begin
          walk_cause = PTW_FLUSH;
        end else begin
          walk_cause = PTW_OK;
          tlb_cs     = 1'b1;
          tlb_we     = 1'b1;
        end
      end
      S_FAULT: begin
        walk_done  = 1'b1;
        walk_cause = tlb_flush_req ? PTW_FLUSH : cause_q;
      end
      S_ABORT: begin
        walk_done  = 1'b1;
        walk_cause = PTW_FLUSH;
      end
      default: begin
        walk_ready = 1'b0;
      end
    endcase
  end

  assign tlb_vpn   = vpn_q;
  assign tlb_spage = spage_q;
  assign tlb_pte   = PTE_W'(pte_q);

endmodule

// File: tb/tb_ptw_sv32.sv
// Self-checking bench for ptw_sv32: directed scenarios followed by random
// walks, each compared against a walk-level reference model of Sv32
// translation with a cycle schedule derived from grant/response delays.
module tb_ptw_sv32;

  localparam int PTE_W = 64;
  localparam int PA_W  = 34;

  localparam logic [1:0] C_OK = 2'd0;
  localparam logic [1:0] C_PF = 2'd1;
  localparam logic [1:0] C_AF = 2'd2;
  localparam logic [1:0] C_FL = 2'd3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             walk_req;
  logic [19:0]      walk_vpn;
  logic             walk_store;
  logic             walk_ready;
  logic             walk_done;
  logic [1:0]       walk_cause;
  logic             satp_mode;
  logic [21:0]      satp_ppn;
  logic             m_req;
  logic [PA_W-1:0]  m_addr;
  logic             m_gnt;
  logic             m_rvalid;
  logic [31:0]      m_rdata;
  logic             m_rerr;
  logic             tlb_cs;
  logic             tlb_we;
  logic [19:0]      tlb_vpn;
  logic             tlb_spage;
  logic [PTE_W-1:0] tlb_pte;
  logic             tlb_flush_req;

  always #5 clk = ~clk;

  ptw_sv32 #(.PTE_W(PTE_W), .PA_W(PA_W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .walk_req      (walk_req),
    .walk_vpn      (walk_vpn),
    .walk_store    (walk_store),
    .walk_ready    (walk_ready),
    .walk_done     (walk_done),
    .walk_cause    (walk_cause),
    .satp_mode     (satp_mode),
    .satp_ppn      (satp_ppn),
    .m_req         (m_req),
    .m_addr        (m_addr),
    .m_gnt         (m_gnt),
    .m_rvalid      (m_rvalid),
    .m_rdata       (m_rdata),
    .m_rerr        (m_rerr),
    .tlb_cs        (tlb_cs),
    .tlb_we        (tlb_we),
    .tlb_vpn       (tlb_vpn),
    .tlb_spage     (tlb_spage),
    .tlb_pte       (tlb_pte),
    .tlb_flush_req (tlb_flush_req)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    walk_req      = 1'b0;
    walk_vpn      = '0;
    walk_store    = 1'b0;
    satp_mode     = 1'b0;
    satp_ppn      = '0;
    m_gnt         = 1'b0;
    m_rvalid      = 1'b0;
    m_rdata       = '0;
    m_rerr        = 1'b0;
    tlb_flush_req = 1'b0;
  endtask

  // Physical memory holding PTEs; unmapped words read as zero (invalid).
  logic [31:0] mem [logic [33:0]];

  function automatic logic [31:0] rd(input logic [33:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  function automatic logic [33:0] tb_addr(input logic [21:0] ppn, input logic [9:0] idx);
    return 34'(ppn) * 34'd4096 + 34'(idx) * 34'd4;
  endfunction

  // Reference model results.
  logic [1:0]  exp_cause;
  logic        exp_spage;
  logic [31:0] exp_pte;
  int          exp_naddr;
  logic [33:0] exp_addr [2];
  int          exp_g [2];
  int          exp_r [2];
  int          exp_done;

  // Walk-level model: translate by the Sv32 rules, then derive when each
  // read is granted/returned and when the walk completes; a flush turns the
  // outcome into cause 3 after any granted read has returned.
  task automatic model_walk(input logic [19:0] vpn, input logic store, input logic mode,
                            input logic [21:0] ppn, input int gd, input int rv,
                            input int err_idx, input int fl);
    logic [21:0] tppn;
    logic [31:0] pte;
    logic [9:0]  idx;
    logic        v, r, w, x, a, d, go_on;
    int          t, nd, keep;
    exp_naddr = 0;
    exp_cause = C_PF;
    exp_spage = 1'b0;
    exp_pte   = '0;
    t         = 0;
    if (!mode) begin
      exp_done = 1;
    end else begin
      tppn  = ppn;
      go_on = 1'b1;
      for (int lvl = 1; lvl >= 0; lvl--) begin
        if (go_on) begin
          idx = (lvl == 1) ? vpn[19:10] : vpn[9:0];
          exp_addr[exp_naddr] = tb_addr(tppn, idx);
          exp_g[exp_naddr]    = t + 1 + gd;
          exp_r[exp_naddr]    = exp_g[exp_naddr] + rv;
          t                   = exp_r[exp_naddr];
          exp_naddr++;
          go_on = 1'b0;
          if (exp_naddr - 1 == err_idx) begin
            exp_cause = C_AF;
          end else begin
            pte = rd(exp_addr[exp_naddr-1]);
            v = pte[0]; r = pte[1]; w = pte[2]; x = pte[3]; a = pte[6]; d = pte[7];
            if (!v || (!r && w)) begin
              exp_cause = C_PF;
            end else if (!r && !x) begin
              if (lvl == 1) begin
                tppn  = pte[31:10];
                go_on = 1'b1;
              end else begin
                exp_cause = C_PF;
              end
            end else if (!a || (store && !d)) begin
              exp_cause = C_PF;
            end else if (lvl == 1 && pte[19:10] != 10'd0) begin
              exp_cause = C_PF;
            end else begin
              exp_cause = C_OK;
              exp_spage = (lvl == 1);
              exp_pte   = pte;
            end
          end
        end
      end
      exp_done = t + 1;
    end
    if (fl >= 1 && fl <= exp_done) begin
      nd   = fl + 1;
      keep = 0;
      for (int i = 0; i < exp_naddr; i++) begin
        if (exp_g[i] <= fl) begin
          keep = i + 1;
          if (fl <= exp_r[i]) nd = exp_r[i] + 1;
        end
      end
      if (fl == exp_done) nd = fl;
      exp_naddr = keep;
      exp_cause = C_FL;
      exp_done  = nd;
    end
  endtask

  // Observed results of the last walk.
  int          obs_done_c;
  logic [1:0]  obs_cause;
  logic [63:0] obs_pte;
  logic        obs_spage;
  logic [19:0] obs_vpn;
  logic [33:0] got_a [$];

  // Runs one walk with a bench-side memory responder: grant after gd held
  // cycles, data rv cycles after the grant, optional bus error on read
  // err_idx, optional one-cycle flush at cycle fl (accept is cycle 0).
  task automatic run_walk(input string tag, input logic [19:0] vpn, input logic store,
                          input logic mode, input logic [21:0] ppn, input int gd,
                          input int rv, input int err_idx, input int fl);
    int          c, rd_idx, hold, ret_c, we_cnt, cs_cnt;
    bit          pend, done;
    logic [33:0] pend_a, held_a;
    model_walk(vpn, store, mode, ppn, gd, rv, err_idx, fl);
    got_a.delete();
    c = 0; rd_idx = 0; hold = 0; ret_c = 0; we_cnt = 0; cs_cnt = 0;
    pend = 0; done = 0; pend_a = '0; held_a = '0;
    obs_done_c = -1; obs_cause = '0; obs_pte = '0; obs_spage = 0; obs_vpn = '0;
    rstn = 1'b1;
    check_val({tag, "/ready"}, 64'(walk_ready), 64'd1);
    while (!done && c < 300) begin
      walk_req      = (c == 0);
      walk_vpn      = vpn;
      walk_store    = store;
      satp_mode     = mode;
      satp_ppn      = ppn;
      tlb_flush_req = (c == fl);
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rerr = 1'b0; m_rdata = '0;
      if (pend && c == ret_c) begin
        m_rvalid = 1'b1;
        m_rdata  = rd(pend_a);
        m_rerr   = (rd_idx - 1 == err_idx);
        pend     = 0;
      end
      if (m_req) begin
        if (hold == 0) held_a = m_addr;
        else check_val({tag, "/addr_stable"}, 64'(m_addr), 64'(held_a));
        if (hold < gd) begin
          hold++;
        end else begin
          m_gnt  = 1'b1;
          pend   = 1;
          pend_a = m_addr;
          ret_c  = c + rv;
          got_a.push_back(m_addr);
          rd_idx++;
          hold = 0;
        end
      end
      #1;
      if (tlb_we) we_cnt++;
      if (tlb_cs) cs_cnt++;
      if (walk_done) begin
        done       = 1;
        obs_done_c = c;
        obs_cause  = walk_cause;
        obs_pte    = tlb_pte;
        obs_spage  = tlb_spage;
        obs_vpn    = tlb_vpn;
      end
      tick();
      c++;
    end
    idle_inputs();
    #1;
    check_val({tag, "/done_seen"}, 64'(done), 64'd1);
    check_val({tag, "/ready_after"}, 64'(walk_ready), 64'd1);
    check_val({tag, "/no_pending"}, 64'(pend), 64'd0);
    check_val({tag, "/cause"}, 64'(obs_cause), 64'(exp_cause));
    check_val({tag, "/done_cycle"}, 64'(obs_done_c), 64'(exp_done));
    check_val({tag, "/we_cnt"}, 64'(we_cnt), (exp_cause == C_OK) ? 64'd1 : 64'd0);
    check_val({tag, "/cs_cnt"}, 64'(cs_cnt), (exp_cause == C_OK) ? 64'd1 : 64'd0);
    check_val({tag, "/nreads"}, 64'(got_a.size()), 64'(exp_naddr));
    for (int i = 0; i < exp_naddr && i < got_a.size(); i++)
      check_val({tag, "/addr"}, 64'(got_a[i]), 64'(exp_addr[i]));
    if (exp_cause == C_OK) begin
      check_val({tag, "/pte"}, obs_pte, {32'h0, exp_pte});
      check_val({tag, "/spage"}, 64'(obs_spage), 64'(exp_spage));
      check_val({tag, "/vpn"}, 64'(obs_vpn), 64'(vpn));
    end
    tick();
  endtask

  function automatic logic [31:0] mk_leaf(input logic [21:0] ppn);
    logic v, r, w, x, u, g, a, d;
    v = ($urandom_range(0, 15) != 0);
    r = 1'($urandom);
    x = 1'($urandom);
    if (!r && !x) x = 1'b1;
    w = r ? 1'($urandom) : ($urandom_range(0, 7) == 0);
    u = 1'($urandom);
    g = 1'($urandom);
    a = ($urandom_range(0, 7) != 0);
    d = 1'($urandom);
    return {ppn, 2'b00, d, a, g, u, x, w, r, v};
  endfunction

  logic [19:0] r_vpn;
  logic [21:0] r_ppn, r_p2, r_lp;
  logic [31:0] r_pte1, r_pte2;
  int          r_k1, r_k2, r_gd, r_rv, r_err, r_fl;
  logic        r_mode, r_store;

  initial begin
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    check_val("rst/ready", 64'(walk_ready), 64'd1);
    check_val("rst/done", 64'(walk_done), 64'd0);
    check_val("rst/m_req", 64'(m_req), 64'd0);
    check_val("rst/m_addr", 64'(m_addr), 64'd0);
    check_val("rst/tlb_we", 64'(tlb_we), 64'd0);
    check_val("rst/tlb_cs", 64'(tlb_cs), 64'd0);
    check_val("rst/tlb_pte", tlb_pte, 64'd0);
    check_val("rst/tlb_vpn", 64'(tlb_vpn), 64'd0);
    check_val("rst/tlb_spage", 64'(tlb_spage), 64'd0);
    check_val("rst/cause", 64'(walk_cause), 64'd0);
    rstn = 1'b1;
    tick();

    // 4 KiB page, best case.
    mem.delete();
    mem[tb_addr(22'h10, 10'h048)] = 32'h00004C01;
    mem[tb_addr(22'h13, 10'h345)] = 32'h200000CF;
    run_walk("page4k", 20'h12345, 1'b0, 1'b1, 22'h10, 0, 1, -1, -1);
    check_val("page4k/c5", 64'(obs_done_c), 64'd5);
    check_val("page4k/pte_const", obs_pte, 64'h200000CF);
    check_val("page4k/spage0", 64'(obs_spage), 64'd0);
    check_val("page4k/l1_addr", 64'(got_a.size() > 0 ? got_a[0] : 34'h0), 64'h10120);

    run_walk("page4k_gnt5", 20'h12345, 1'b0, 1'b1, 22'h10, 5, 2, -1, -1);
    run_walk("page4k_rerr", 20'h12345, 1'b0, 1'b1, 22'h10, 0, 1, 1, -1);
    check_val("page4k_rerr/af", 64'(obs_cause), 64'(C_AF));
    run_walk("flush_l1wait", 20'h12345, 1'b0, 1'b1, 22'h10, 0, 3, -1, 2);
    check_val("flush_l1wait/c5", 64'(obs_done_c), 64'd5);
    run_walk("flush_fill", 20'h12345, 1'b0, 1'b1, 22'h10, 0, 1, -1, 5);
    check_val("flush_fill/c5", 64'(obs_done_c), 64'd5);
    run_walk("flush_req", 20'h12345, 1'b0, 1'b1, 22'h10, 3, 1, -1, 1);
    run_walk("bare_mode", 20'h12345, 1'b0, 1'b0, 22'h10, 0, 1, -1, -1);

    // Megapage and leaf-level faults at the root.
    mem[tb_addr(22'h10, 10'h048)] = 32'h200000CF;
    run_walk("mega", 20'h12345, 1'b1, 1'b1, 22'h10, 0, 1, -1, -1);
    check_val("mega/c3", 64'(obs_done_c), 64'd3);
    check_val("mega/spage1", 64'(obs_spage), 64'd1);
    mem[tb_addr(22'h10, 10'h048)] = 32'h200004CF;
    run_walk("mega_misalign", 20'h12345, 1'b0, 1'b1, 22'h10, 0, 1, -1, -1);
    mem[tb_addr(22'h10, 10'h048)] = 32'h00004C00;
    run_walk("invalid", 20'h12345, 1'b0, 1'b1, 22'h10, 0, 1, -1, -1);
    mem[tb_addr(22'h10, 10'h048)] = 32'h00000005;
    run_walk("w_no_r", 20'h12345, 1'b0, 1'b1, 22'h10, 0, 1, -1, -1);
    mem[tb_addr(22'h10, 10'h048)] = 32'h2000005F;
    run_walk("store_nod", 20'h12345, 1'b1, 1'b1, 22'h10, 0, 1, -1, -1);
    check_val("store_nod/pf", 64'(obs_cause), 64'(C_PF));
    run_walk("load_nod", 20'h12345, 1'b0, 1'b1, 22'h10, 0, 1, -1, -1);

    // Flush while idle: no activity.
    tlb_flush_req = 1'b1;
    #1;
    check_val("idle_flush/done", 64'(walk_done), 64'd0);
    check_val("idle_flush/we", 64'(tlb_we), 64'd0);
    tick();
    tlb_flush_req = 1'b0;
    #1;
    check_val("idle_flush/ready", 64'(walk_ready), 64'd1);
    check_val("idle_flush/m_req", 64'(m_req), 64'd0);
    tick();

    // Reset in L0_WAIT, then a late response arrives in IDLE.
    mem.delete();
    mem[tb_addr(22'h10, 10'h048)] = 32'h00004C01;
    walk_req = 1'b1; walk_vpn = 20'h12345; satp_mode = 1'b1; satp_ppn = 22'h10;
    tick();
    idle_inputs();
    check_val("rst_mid/l1_req", 64'(m_req), 64'd1);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00004C01;
    tick();
    m_rvalid = 1'b0; m_rdata = '0;
    check_val("rst_mid/l0_req", 64'(m_req), 64'd1);
    check_val("rst_mid/l0_addr", 64'(m_addr), 64'h13D14);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    rstn  = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
    check_val("rst_mid/ready", 64'(walk_ready), 64'd1);
    check_val("rst_mid/m_req", 64'(m_req), 64'd0);
    check_val("rst_mid/tlb_vpn", 64'(tlb_vpn), 64'd0);
    tick();
    m_rvalid = 1'b1; m_rdata = 32'h200000CF;
    #1;
    check_val("rst_mid/late_done", 64'(walk_done), 64'd0);
    check_val("rst_mid/late_we", 64'(tlb_we), 64'd0);
    tick();
    m_rvalid = 1'b0; m_rdata = '0;
    #1;
    check_val("rst_mid/still_idle", 64'(walk_ready), 64'd1);
    check_val("rst_mid/no_req", 64'(m_req), 64'd0);
    tick();

    // Random walks.
    for (int n = 0; n < 300; n++) begin
      mem.delete();
      r_vpn   = 20'($urandom);
      r_ppn   = 22'($urandom);
      r_store = 1'($urandom);
      r_mode  = ($urandom_range(0, 15) != 0);
      r_k1    = $urandom_range(0, 3);
      r_lp    = 22'($urandom);
      if ($urandom_range(0, 3) != 0) r_lp[9:0] = '0;
      if (r_k1 <= 1) begin
        r_p2   = 22'($urandom);
        r_pte1 = {r_p2, 10'h001};
        r_k2   = $urandom_range(0, 7);
        if (r_k2 < 6)       r_pte2 = mk_leaf(22'($urandom));
        else if (r_k2 == 6) r_pte2 = {22'($urandom), 10'h001};
        else                r_pte2 = $urandom;
        mem[tb_addr(r_ppn, r_vpn[19:10])] = r_pte1;
        mem[tb_addr(r_p2, r_vpn[9:0])]    = r_pte2;
      end else if (r_k1 == 2) begin
        mem[tb_addr(r_ppn, r_vpn[19:10])] = mk_leaf(r_lp);
      end else begin
        mem[tb_addr(r_ppn, r_vpn[19:10])] = $urandom;
      end
      r_gd  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      r_rv  = $urandom_range(1, 3);
      r_err = $urandom_range(0, 7);
      if (r_err > 1) r_err = -1;
      r_fl  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 14) : -1;
      run_walk("rand", r_vpn, r_store, r_mode, r_ppn, r_gd, r_rv, r_err, r_fl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
